// File: rtl/rega_timer_if.sv
// rega_timer_if: sensor, configuration and timer-side signals of the irrigation timer sequencer.
interface rega_timer_if;
  logic       tick_i, start_i, cancel_i, dry_i, tank_ok_i, timer_zero_i;
  logic [3:0] cfg_dm_i, cfg_um_i, cfg_ds_i, cfg_us_i;
  logic       load_o, timer_tick_o, valve_o, done_o, fault_o;
  logic [3:0] preset_dm_o, preset_um_o, preset_ds_o, preset_us_o;
  logic [1:0] seletor_o;
  logic [2:0] state_o;
  modport slave (
    input  tick_i, start_i, cancel_i, dry_i, tank_ok_i, timer_zero_i,
    input  cfg_dm_i, cfg_um_i, cfg_ds_i, cfg_us_i,
    output load_o, timer_tick_o, valve_o, done_o, fault_o,
    output preset_dm_o, preset_um_o, preset_ds_o, preset_us_o, seletor_o, state_o
  );
  modport master (
    output tick_i, start_i, cancel_i, dry_i, tank_ok_i, timer_zero_i,
    output cfg_dm_i, cfg_um_i, cfg_ds_i, cfg_us_i,
    input  load_o, timer_tick_o, valve_o, done_o, fault_o,
    input  preset_dm_o, preset_um_o, preset_ds_o, preset_us_o, seletor_o, state_o
  );
endinterface

// File: rtl/rega_timer_controller.sv
// rega_timer_controller: loads the BCD duration, gates 1 Hz ticks to the MM:SS timer, drives the valve and scans digits.
module rega_timer_controller #(
  parameter int SCAN_DIV   = 1000,
  parameter int SETTLE_TKS = 2,
  parameter int PAUSE_MAX  = 60
) (
  input logic        new_clock,
  input logic        reset,
  rega_timer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WATER, PAUSE, DONE, FAULT} state_e;
  localparam int CW = $clog2((PAUSE_MAX > SETTLE_TKS ? PAUSE_MAX : SETTLE_TKS) + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   scan_q;
  logic [1:0]      sel_q;
  logic [15:0]     preset_q, preset_d;
  logic [15:0]     cfg;
  logic            cfg_ok, accept, scan_wrap;
  assign cfg       = {bus.cfg_dm_i, bus.cfg_um_i, bus.cfg_ds_i, bus.cfg_us_i};
  assign cfg_ok    = bus.cfg_us_i <= 4'd9 && bus.cfg_um_i <= 4'd9 && bus.cfg_ds_i <= 4'd5 && bus.cfg_dm_i <= 4'd5;
  assign accept    = bus.start_i & bus.dry_i;
  assign scan_wrap = scan_q == SW'(SCAN_DIV - 1);
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    case (state_q)
      IDLE, DONE: if (accept) begin
        state_d  = cfg_ok ? LOAD : FAULT;
        preset_d = cfg_ok ? cfg : preset_q;
      end
      LOAD:   state_d = SETTLE;
      SETTLE: state_d = bus.timer_zero_i ? DONE
                      : (bus.tick_i && cnt_q == CW'(SETTLE_TKS - 1)) ? (bus.tank_ok_i ? WATER : PAUSE)
                      : SETTLE;
      WATER:  state_d = bus.timer_zero_i ? DONE : !bus.tank_ok_i ? PAUSE : WATER;
      PAUSE:  state_d = bus.tank_ok_i ? WATER
                      : (bus.tick_i && cnt_q == CW'(PAUSE_MAX - 1)) ? FAULT
                      : PAUSE;
      FAULT:  state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (bus.cancel_i) begin
      state_d  = IDLE;
      preset_d = preset_q;
    end
    // Tick counter serves SETTLE and PAUSE; any state change restarts it.
    cnt_d = (state_d != state_q || !(state_q inside {SETTLE, PAUSE})) ? '0 : cnt_q + CW'(bus.tick_i);
  end
  always_ff @(posedge new_clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      preset_q <= '0;
      scan_q   <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      scan_q   <= scan_wrap ? '0 : scan_q + SW'(1);
      sel_q    <= sel_q + 2'(scan_wrap);
    end
  end
  assign bus.load_o       = state_q == LOAD;
  assign bus.valve_o      = state_q == WATER;
  assign bus.timer_tick_o = bus.tick_i && state_q == WATER && !bus.timer_zero_i;
  assign bus.done_o       = state_q == DONE;
  assign bus.fault_o      = state_q == FAULT;
  assign bus.state_o      = state_q;
  assign bus.seletor_o    = sel_q;
  assign {bus.preset_dm_o, bus.preset_um_o, bus.preset_ds_o, bus.preset_us_o} = preset_q;
endmodule

// File: tb/tb_rega_timer_controller.sv
// tb_rega_timer_controller: directed irrigation scenarios checked every cycle against a rule-level model and a seconds-count timer.
module tb_rega_timer_controller;
  localparam int SD = 4, ST = 2, PM = 60;
  localparam int IDLE = 0, LOAD = 1, SETTLE = 2, WATER = 3, PAUSE = 4, DONE = 5, FAULT = 6;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  int rem = 0;
  int n_tt = 0, n_load = 0, n_valve = 0;
  int m_st = IDLE, m_ticks = 0, m_cyc = 0;
  logic [15:0] m_pre = '0;
  bit armed = 0;
  rega_timer_if bus();
  rega_timer_controller #(.SCAN_DIV(SD), .SETTLE_TKS(ST), .PAUSE_MAX(PM)) dut (
    .new_clock(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // Behavioural MM:SS timer held as a plain seconds count.
  assign bus.timer_zero_i = (rem == 0);
  always @(posedge clk)
    if (bus.load_o)
      rem <= int'(bus.preset_dm_o) * 600 + int'(bus.preset_um_o) * 60 + int'(bus.preset_ds_o) * 10 + int'(bus.preset_us_o);
    else if (bus.timer_tick_o && rem > 0)
      rem <= rem - 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    logic [15:0] cfg;
    bit ok;
    int nx;
    cfg = {bus.cfg_dm_i, bus.cfg_um_i, bus.cfg_ds_i, bus.cfg_us_i};
    ok  = cfg[3:0] < 10 && cfg[11:8] < 10 && cfg[7:4] < 6 && cfg[15:12] < 6;
    if (rst) begin
      m_st = IDLE; m_ticks = 0; m_cyc = 0; m_pre = '0; armed = 1;
    end else begin
      m_cyc++;
      nx = m_st;
      if (bus.cancel_i) nx = IDLE;
      else if ((m_st == IDLE || m_st == DONE) && bus.start_i && bus.dry_i) begin
        nx = ok ? LOAD : FAULT;
        if (ok) m_pre = cfg;
      end
      else if (m_st == LOAD) nx = SETTLE;
      else if (m_st == SETTLE) begin
        if (bus.timer_zero_i) nx = DONE;
        else if (bus.tick_i && m_ticks + 1 == ST) nx = bus.tank_ok_i ? WATER : PAUSE;
      end
      else if (m_st == WATER) nx = bus.timer_zero_i ? DONE : (!bus.tank_ok_i ? PAUSE : WATER);
      else if (m_st == PAUSE) begin
        if (bus.tank_ok_i) nx = WATER;
        else if (bus.tick_i && m_ticks + 1 == PM) nx = FAULT;
      end
      m_ticks = (nx != m_st) ? 0 : m_ticks + int'(bus.tick_i);
      m_st = nx;
    end
  end
  always @(negedge clk) begin
    n_tt    += int'(bus.timer_tick_o);
    n_load  += int'(bus.load_o);
    n_valve += int'(bus.valve_o);
    if (armed) begin
      check("state", 32'(bus.state_o), 32'(m_st));
      check("load", 32'(bus.load_o), 32'(m_st == LOAD));
      check("valve", 32'(bus.valve_o), 32'(m_st == WATER));
      check("done", 32'(bus.done_o), 32'(m_st == DONE));
      check("fault", 32'(bus.fault_o), 32'(m_st == FAULT));
      check("timer_tick", 32'(bus.timer_tick_o), 32'(bus.tick_i && m_st == WATER && !bus.timer_zero_i));
      check("seletor", 32'(bus.seletor_o), 32'((m_cyc / SD) % 4));
      check("preset", 32'({bus.preset_dm_o, bus.preset_um_o, bus.preset_ds_o, bus.preset_us_o}), 32'(m_pre));
    end
  end
  initial begin
    bus.tick_i = 0;
    forever begin
      repeat (2) @(posedge clk);
      #1 bus.tick_i = 1;
      @(posedge clk);
      #1 bus.tick_i = 0;
    end
  end
  task automatic go(input logic [3:0] dm, um, ds, us);
    {bus.cfg_dm_i, bus.cfg_um_i, bus.cfg_ds_i, bus.cfg_us_i} = {dm, um, ds, us};
    bus.start_i = 1;
    @(posedge clk);
    #1 bus.start_i = 0;
  endtask
  task automatic wait_st(input int s, input int lim, input string name);
    for (int i = 0; i < lim && int'(bus.state_o) != s; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(bus.state_o), 32'(s));
  endtask
  task automatic pulse_cancel();
    bus.cancel_i = 1;
    @(posedge clk);
    #1 bus.cancel_i = 0;
  endtask
  initial begin
    int b_tt, b_ld, b_v;
    {bus.start_i, bus.cancel_i} = '0;
    bus.dry_i = 1;
    bus.tank_ok_i = 1;
    {bus.cfg_dm_i, bus.cfg_um_i, bus.cfg_ds_i, bus.cfg_us_i} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("reset_state", 32'(bus.state_o), 0);
    check("reset_sel", 32'(bus.seletor_o), 0);
    repeat (8) @(posedge clk);
    #1 check("sel_after_8", 32'(bus.seletor_o), 2);
    b_tt = n_tt; b_ld = n_load;
    go(0, 1, 3, 0);
    wait_st(DONE, 600, "done_0130");
    check("ticks_0130", 32'(n_tt - b_tt), 90);
    check("load_once_0130", 32'(n_load - b_ld), 1);
    check("valve_off_done", 32'(bus.valve_o), 0);
    b_tt = n_tt; b_ld = n_load; b_v = n_valve;
    go(0, 0, 0, 0);
    wait_st(DONE, 20, "done_0000");
    check("valve_never_0000", 32'(n_valve - b_v), 0);
    check("ticks_0000", 32'(n_tt - b_tt), 0);
    check("load_once_0000", 32'(n_load - b_ld), 1);
    b_ld = n_load;
    go(0, 0, 0, 4'hA);
    wait_st(FAULT, 5, "fault_bad_us");
    check("fault_flag", 32'(bus.fault_o), 1);
    check("no_load_bad", 32'(n_load - b_ld), 0);
    pulse_cancel();
    check("cancel_fault_idle", 32'(bus.state_o), IDLE);
    check("fault_cleared", 32'(bus.fault_o), 0);
    go(0, 2, 0, 0);
    wait_st(WATER, 20, "water_0200");
    bus.tank_ok_i = 0;
    @(posedge clk);
    #1 b_tt = n_tt;
    repeat (14) @(posedge clk);
    #1 check("pause_state", 32'(bus.state_o), PAUSE);
    check("pause_valve", 32'(bus.valve_o), 0);
    check("pause_no_ticks", 32'(n_tt - b_tt), 0);
    bus.tank_ok_i = 1;
    wait_st(WATER, 5, "resume_water");
    bus.tank_ok_i = 0;
    wait_st(FAULT, 400, "pause_timeout_fault");
    bus.tank_ok_i = 1;
    pulse_cancel();
    {bus.cfg_dm_i, bus.cfg_um_i, bus.cfg_ds_i, bus.cfg_us_i} = 16'h0005;
    bus.start_i = 1; bus.cancel_i = 1;
    @(posedge clk);
    #1 check("start_cancel_idle", 32'(bus.state_o), IDLE);
    bus.start_i = 0; bus.cancel_i = 0;
    go(0, 5, 0, 0);
    wait_st(WATER, 20, "water_0500");
    pulse_cancel();
    check("cancel_valve", 32'(bus.valve_o), 0);
    go(0, 5, 0, 0);
    wait_st(WATER, 20, "water_0500_b");
    rst = 1;
    @(posedge clk);
    #1 check("reset_valve", 32'(bus.valve_o), 0);
    check("reset_sel_mid", 32'(bus.seletor_o), 0);
    check("reset_preset", 32'({bus.preset_dm_o, bus.preset_um_o}), 0);
    rst = 0;
    repeat (6) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
